load_use_hazard_unit: RTL and testbench

//  Stall/bubble controller paired with the EX-stage forwarding mux. Detects RAW hazards that

---
 rtl/load_use_hazard_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_use_hazard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_unit.sv
// -----------------------------------------------------------------------------
// load_use_hazard_unit
//
// Purpose:
//   Stall and bubble controller that works alongside the EX-stage forwarding
//   mux. It detects the one RAW hazard that forwarding cannot cover: a load in
//   EX whose destination is read by the instruction in ID. For that hazard it
//   holds PC and IF/ID and injects a single bubble into ID/EX. While an
//   instruction or data memory access is outstanding it freezes the whole
//   pipeline. It also runs a memory-wait watchdog and two saturating
//   performance counters.
//
// Parameters:
//   CNT_W     width of the perf counters
//   MAX_WAIT  consecutive memory-busy cycles before mem_timeout_o sets (>= 2)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   ID_*                 valid flag, source registers and source-use flags of
//                        the instruction in ID
//   EX_rd_i / EX_is_load_i / EX_load_regfile_i
//                        destination, load flag and regfile-write flag in EX
//   imem_read_i / imem_resp_i   fetch outstanding / fetch response
//   dmem_req_i / dmem_resp_i    data access outstanding / data response
//   clr_cnt_i            synchronous clear of counters and timeout flag
//   IF_ID_stall_o        hold PC and IF/ID (combinational)
//   ID_EX_bubble_o       load a NOP into ID/EX (combinational)
//   pipeline_stall_o     freeze all pipeline registers (combinational)
//   mem_timeout_o        sticky watchdog flag (registered)
//   load_use_cnt_o       bubbles inserted, saturating (registered)
//   mem_stall_cnt_o      memory-freeze cycles, saturating (registered)
// -----------------------------------------------------------------------------
module load_use_hazard_unit #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_uses_rs1_i,
  input  logic             ID_uses_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_is_load_i,
  input  logic             EX_load_regfile_i,
  input  logic             imem_read_i,
  input  logic             imem_resp_i,
  input  logic             dmem_req_i,
  input  logic             dmem_resp_i,
  input  logic             clr_cnt_i,
  output logic             IF_ID_stall_o,
  output logic             ID_EX_bubble_o,
  output logic             pipeline_stall_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o
);

  // Wait counter must be able to hold MAX_WAIT itself (saturation point).
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ALL1  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Saturating increment: stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] value,
    input logic             en
  );
    logic [CNT_W-1:0] res;
    if (en && (value != CNT_ALL1)) begin
      res = value + CNT_ONE;
    end else begin
      res = value;
    end
    return res;
  endfunction

  // A source field only matters when the instruction actually reads it.
  function automatic logic src_hit(
    input logic       uses,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return uses & (rs == rd);
  endfunction

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  ms_cnt_q, ms_cnt_d;

  logic mem_busy_s;
  logic lu_s;
  logic bubble_s;
  logic timeout_hit_s;

  // Hazard and memory-busy detection; memory freeze overrides the bubble so
  // the load-use check is simply re-evaluated once memory completes.
  always_comb begin
    mem_busy_s = (imem_read_i & ~imem_resp_i) | (dmem_req_i & ~dmem_resp_i);
    lu_s       = ID_valid_i & EX_is_load_i & EX_load_regfile_i &
                 (EX_rd_i != 5'd0) &
                 (src_hit(ID_uses_rs1_i, ID_rs1_i, EX_rd_i) |
                  src_hit(ID_uses_rs2_i, ID_rs2_i, EX_rd_i));
    bubble_s   = lu_s & ~mem_busy_s;
  end

  assign pipeline_stall_o = mem_busy_s;
  assign IF_ID_stall_o    = bubble_s;
  assign ID_EX_bubble_o   = bubble_s;
  assign mem_timeout_o    = timeout_q;
  assign load_use_cnt_o   = lu_cnt_q;
  assign mem_stall_cnt_o  = ms_cnt_q;

  // Watchdog FSM next state: wait_cnt counts consecutive busy cycles and
  // flags the hit on the edge where it reaches MAX_WAIT.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_hit_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy_s) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy_s) begin
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end else if (wait_cnt_q < WAIT_MAX) begin
          state_d       = ST_MEM_WAIT;
          wait_cnt_d    = wait_cnt_q + WAIT_ONE;
          timeout_hit_s = (wait_cnt_q == (WAIT_MAX - WAIT_ONE));
        end else begin
          // Saturated: hold the count, no fresh hit.
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase
  end

  // Sticky timeout flag and perf counters; clear wins over set/increment.
  always_comb begin
    timeout_d = timeout_q;
    lu_cnt_d  = lu_cnt_q;
    ms_cnt_d  = ms_cnt_q;
    if (clr_cnt_i) begin
      timeout_d = 1'b0;
      lu_cnt_d  = CNT_ZERO;
      ms_cnt_d  = CNT_ZERO;
    end else begin
      timeout_d = timeout_q | timeout_hit_s;
      lu_cnt_d  = sat_inc(lu_cnt_q, bubble_s);
      ms_cnt_d  = sat_inc(ms_cnt_q, mem_busy_s);
    end
  end

  // State register for FSM, watchdog, flag and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= WAIT_ZERO;
      timeout_q  <= 1'b0;
      lu_cnt_q   <= CNT_ZERO;
      ms_cnt_q   <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      lu_cnt_q   <= lu_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_load_use_hazard_unit
//
// Purpose:
//   Self-checking bench for load_use_hazard_unit (CNT_W=4, MAX_WAIT=4).
//   A behavioural model (busy run length, integer counters clamped at the
//   saturation value) is compared against the DUT on every falling edge.
//   Directed scenarios carry hand-computed literal expectations, then a
//   randomized phase exercises hazards, memory bursts, clears and resets.
// -----------------------------------------------------------------------------
module tb_load_use_hazard_unit;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic id_u1 = 1'b0;
  logic id_u2 = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic ex_ld = 1'b0;
  logic ex_wr = 1'b0;
  logic imem_read = 1'b0;
  logic imem_resp = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_resp = 1'b0;
  logic clr = 1'b0;

  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             pipe_stall;
  logic             mem_timeout;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] ms_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_run = 0;
  int m_tmo = 0;
  int m_lu  = 0;
  int m_ms  = 0;
  int e_busy;
  int e_haz;
  int e_bub;

  load_use_hazard_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk               (clk),
    .rst               (rst),
    .ID_valid_i        (id_valid),
    .ID_rs1_i          (id_rs1),
    .ID_rs2_i          (id_rs2),
    .ID_uses_rs1_i     (id_u1),
    .ID_uses_rs2_i     (id_u2),
    .EX_rd_i           (ex_rd),
    .EX_is_load_i      (ex_ld),
    .EX_load_regfile_i (ex_wr),
    .imem_read_i       (imem_read),
    .imem_resp_i       (imem_resp),
    .dmem_req_i        (dmem_req),
    .dmem_resp_i       (dmem_resp),
    .clr_cnt_i         (clr),
    .IF_ID_stall_o     (if_id_stall),
    .ID_EX_bubble_o    (id_ex_bubble),
    .pipeline_stall_o  (pipe_stall),
    .mem_timeout_o     (mem_timeout),
    .load_use_cnt_o    (lu_cnt),
    .mem_stall_cnt_o   (ms_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    if (rst) begin
      m_run = 0; m_tmo = 0; m_lu = 0; m_ms = 0;
    end
    e_busy = ((imem_read && !imem_resp) || (dmem_req && !dmem_resp)) ? 1 : 0;
    e_haz  = (id_valid && ex_ld && ex_wr && ex_rd != 5'd0 &&
              ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd))) ? 1 : 0;
    e_bub  = (e_haz == 1 && e_busy == 0) ? 1 : 0;
    check("pipeline_stall", 32'(pipe_stall), 32'(e_busy));
    check("if_id_stall", 32'(if_id_stall), 32'(e_bub));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    check("load_use_cnt", 32'(lu_cnt), 32'(m_lu));
    check("mem_stall_cnt", 32'(ms_cnt), 32'(m_ms));
    if (!rst) begin
      m_run = (e_busy == 1) ? m_run + 1 : 0;
      if (e_busy == 1 && m_run == MAX_WAIT) m_tmo = 1;
      m_lu = (m_lu + e_bub > CNT_SAT) ? CNT_SAT : m_lu + e_bub;
      m_ms = (m_ms + e_busy > CNT_SAT) ? CNT_SAT : m_ms + e_busy;
      if (clr) begin
        m_tmo = 0; m_lu = 0; m_ms = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_u1 = 1'b0; id_u2 = 1'b0;
    ex_rd = 5'd0; ex_ld = 1'b0; ex_wr = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
    clr = 1'b0;
  endtask

  task automatic set_haz(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd);
    id_valid = 1'b1; id_rs1 = rs1; id_u1 = u1; id_rs2 = rs2; id_u2 = u2;
    ex_rd = rd; ex_ld = 1'b1; ex_wr = 1'b1;
  endtask

  int burst = 0;

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset lu_cnt", 32'(lu_cnt), 32'd0);
    check("reset ms_cnt", 32'(ms_cnt), 32'd0);
    check("reset timeout", 32'(mem_timeout), 32'd0);

    // 1: lw x5 in EX, add x6,x5,x7 in ID
    tick(); idle(); set_haz(5'd5, 1'b1, 5'd7, 1'b1, 5'd5); #1;
    check("t1 if_id_stall", 32'(if_id_stall), 32'd1);
    check("t1 bubble", 32'(id_ex_bubble), 32'd1);
    tick(); ex_ld = 1'b0; #1;
    check("t1 bubble gone", 32'(id_ex_bubble), 32'd0);
    check("t1 lu_cnt", 32'(lu_cnt), 32'd1);

    // 2: rd=x0, unused rs2 match, squashed ID
    tick(); idle(); set_haz(5'd0, 1'b1, 5'd0, 1'b1, 5'd0); #1;
    check("t2 rd0", 32'(id_ex_bubble), 32'd0);
    tick(); set_haz(5'd6, 1'b1, 5'd5, 1'b0, 5'd5); #1;
    check("t2 unused rs2", 32'(id_ex_bubble), 32'd0);
    tick(); set_haz(5'd5, 1'b1, 5'd5, 1'b1, 5'd5); id_valid = 1'b0; #1;
    check("t2 invalid", 32'(if_id_stall), 32'd0);
    tick(); idle(); #1;
    check("t2 lu_cnt", 32'(lu_cnt), 32'd1);

    // 3: load-use under a 3-cycle data memory wait
    tick(); set_haz(5'd5, 1'b1, 5'd7, 1'b1, 5'd5); dmem_req = 1'b1; #1;
    check("t3 stall c1", 32'(pipe_stall), 32'd1);
    check("t3 bubble c1", 32'(id_ex_bubble), 32'd0);
    repeat (2) begin
      tick(); #1;
      check("t3 stall", 32'(pipe_stall), 32'd1);
      check("t3 bubble held", 32'(id_ex_bubble), 32'd0);
    end
    tick(); dmem_resp = 1'b1; #1;
    check("t3 stall released", 32'(pipe_stall), 32'd0);
    check("t3 bubble fires", 32'(id_ex_bubble), 32'd1);
    tick(); idle(); #1;
    check("t3 ms_cnt", 32'(ms_cnt), 32'd3);
    check("t3 lu_cnt", 32'(lu_cnt), 32'd2);

    // 4: watchdog with MAX_WAIT=4
    tick(); dmem_req = 1'b1;
    repeat (3) tick();
    #1;
    check("t4 timeout early", 32'(mem_timeout), 32'd0);
    tick(); #1;
    check("t4 timeout set", 32'(mem_timeout), 32'd1);
    repeat (2) tick();
    dmem_resp = 1'b1;
    tick(); idle(); #1;
    check("t4 timeout sticky", 32'(mem_timeout), 32'd1);
    check("t4 ms_cnt", 32'(ms_cnt), 32'd9);
    clr = 1'b1;
    tick(); clr = 1'b0; #1;
    check("t4 clr timeout", 32'(mem_timeout), 32'd0);
    check("t4 clr ms_cnt", 32'(ms_cnt), 32'd0);
    check("t4 clr lu_cnt", 32'(lu_cnt), 32'd0);

    // 5: saturate load_use_cnt, then clear alongside a bubble
    for (int i = 0; i < 17; i++) begin
      tick(); set_haz(5'd5, 1'b1, 5'd7, 1'b1, 5'd5);
      tick(); idle();
    end
    #1;
    check("t5 saturated", 32'(lu_cnt), 32'd15);
    tick(); set_haz(5'd9, 1'b0, 5'd9, 1'b1, 5'd9); clr = 1'b1;
    tick(); idle(); #1;
    check("t5 clr wins", 32'(lu_cnt), 32'd0);

    // 6: reset mid-wait, wait restarts at 1 afterwards
    tick(); dmem_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1; #1;
    check("t6 rst ms_cnt", 32'(ms_cnt), 32'd0);
    check("t6 rst timeout", 32'(mem_timeout), 32'd0);
    check("t6 stall follows", 32'(pipe_stall), 32'd1);
    tick(); rst = 1'b0;
    repeat (3) tick();
    #1;
    check("t6 restart early", 32'(mem_timeout), 32'd0);
    tick(); #1;
    check("t6 restart timeout", 32'(mem_timeout), 32'd1);
    tick(); idle(); clr = 1'b1;
    tick(); idle();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      id_valid  = 1'($urandom_range(0, 3) != 0);
      id_rs1    = 5'($urandom_range(0, 3));
      id_rs2    = 5'($urandom_range(0, 3));
      id_u1     = 1'($urandom_range(0, 1));
      id_u2     = 1'($urandom_range(0, 1));
      ex_rd     = 5'($urandom_range(0, 3));
      ex_ld     = 1'($urandom_range(0, 1));
      ex_wr     = 1'($urandom_range(0, 3) != 0);
      imem_read = 1'($urandom_range(0, 1));
      imem_resp = 1'($urandom_range(0, 2) != 0);
      clr       = 1'($urandom_range(0, 63) == 0);
      if (burst > 0) begin
        burst--;
        dmem_req = 1'b1; dmem_resp = 1'b0;
      end else begin
        if ($urandom_range(0, 15) == 0) burst = $urandom_range(2, 8);
        dmem_req  = 1'($urandom_range(0, 1));
        dmem_resp = 1'($urandom_range(0, 1));
      end
    end

    tick(); idle(); rst = 1'b0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
